onehot_rr_arbiter: RTL and testbench

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

---
 rtl/onehot_rr_arbiter_if.sv | 30 +++
 rtl/onehot_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between requesters and the one-hot round-robin arbiter.
// master = requester side, slave = arbiter side.
interface onehot_rr_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [N-1:0] prio_ptr;
  logic [2:0]   fsm_state;
  logic         preempt;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  prio_ptr,
    input  fsm_state,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output prio_ptr,
    output fsm_state,
    output preempt
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and pointer, per-tenure hold limit and
// a mandatory one-cycle gap between tenures. All outputs are registered.
module onehot_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  onehot_rr_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_GAP  = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          preempt_q, preempt_d;
  logic          grant_valid_q;

  // First set request at or above the pointer bit, wrapping N-1 -> 0.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] g;
    logic         found;
    int           base;
    int           idx;
    g     = '0;
    found = 1'b0;
    base  = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        base = i;
      end else begin
        base = base;
      end
    end
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!found && r[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
    return g;
  endfunction

  // Next pointer: one position above the released grant bit.
  function automatic logic [N-1:0] rotate_up(input logic [N-1:0] g);
    return {g[N-2:0], g[N-1]};
  endfunction

  // Next-state, grant, pointer and hold-counter decode.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          grant_d = rr_pick(bus.req, ptr_q);
          state_d = ST_BUSY;
          cnt_d   = CW'(1);
        end else begin
          grant_d = '0;
        end
      end
      ST_BUSY: begin
        if ((bus.req & grant_q) == '0) begin
          grant_d = '0;
          ptr_d   = rotate_up(grant_q);
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q >= CW'(MAX_HOLD)) begin
          grant_d   = '0;
          ptr_d     = rotate_up(grant_q);
          cnt_d     = '0;
          state_d   = ST_GAP;
          preempt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        // Illegal encoding: recover to a clean idle with the reset pointer.
        grant_d = '0;
        ptr_d   = {{(N-1){1'b0}}, 1'b1};
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      ptr_q         <= {{(N-1){1'b0}}, 1'b1};
      cnt_q         <= '0;
      preempt_q     <= 1'b0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      preempt_q     <= preempt_d;
      grant_valid_q <= |grant_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.prio_ptr    = ptr_q;
  assign bus.fsm_state   = state_q;
  assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random request traffic compared
// against an index-based behavioural model of the arbitration rules.
module tb_onehot_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic reset;

  onehot_rr_arbiter_if #(.N(N)) bus ();

  onehot_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 idle, 1 holding a tenure, 2 gap; owner/pointer as plain indices.
  int m_phase;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_pre;

  a_fsm_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(bus.fsm_state))
    else $error("fsm_state not one-hot");
  a_ptr_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(bus.prio_ptr))
    else $error("prio_ptr not one-hot");
  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.grant))
    else $error("grant multi-hot");
  a_gv: assert property (@(posedge clk) disable iff (reset) bus.grant_valid == (bus.grant != '0))
    else $error("grant_valid inconsistent");
  a_no_switch: assert property (@(posedge clk) disable iff (reset)
    ($past(bus.grant) != '0 && bus.grant != '0) |-> bus.grant == $past(bus.grant))
    else $error("grant switched directly");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_pre   = 1'b0;
  endtask

  task automatic m_edge(input logic [N-1:0] r);
    m_pre = 1'b0;
    if (m_phase == 0) begin
      if (r != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_phase = 1;
        m_hold  = 1;
      end
    end else if (m_phase == 1) begin
      if (!r[m_owner] || m_hold == MAX_HOLD) begin
        m_pre   = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_phase = 2;
      end else begin
        m_hold = m_hold + 1;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] one;
    logic [N-1:0] eg;
    logic [N-1:0] ep;
    logic [2:0]   fs;
    one = 1;
    eg  = (m_phase == 1) ? (one << m_owner) : '0;
    ep  = one << m_ptr;
    fs  = 3'b001 << m_phase;
    check({tag, ".grant"},   32'(bus.grant),       32'(eg));
    check({tag, ".gvalid"},  32'(bus.grant_valid), 32'(eg != '0));
    check({tag, ".ptr"},     32'(bus.prio_ptr),    32'(ep));
    check({tag, ".state"},   32'(bus.fsm_state),   32'(fs));
    check({tag, ".preempt"}, 32'(bus.preempt),     32'(m_pre));
  endtask

  task automatic step(input string tag, input logic [N-1:0] r);
    bus.req = r;
    @(posedge clk);
    m_edge(r);
    #1;
    check_model(tag);
  endtask

  // Assert reset between edges, check its immediate effect, release before the next edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    check({tag, ".rst_grant"}, 32'(bus.grant),     32'(0));
    check({tag, ".rst_state"}, 32'(bus.fsm_state), 32'(3'b001));
    check({tag, ".rst_ptr"},   32'(bus.prio_ptr),  32'(4'b0001));
    check_model(tag);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int pre_cnt;
    logic [N-1:0] r;
    logic [N-1:0] one;
    one     = 1;
    reset   = 1'b1;
    bus.req = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    step("idle0", 4'b0000);
    step("idle1", 4'b0000);

    // Single requester held three cycles.
    for (int i = 0; i < 3; i++) begin
      step("single", 4'b0100);
      check("single.g", 32'(bus.grant), 32'(4'b0100));
    end
    step("single.rel", 4'b0000);
    check("single.ptr", 32'(bus.prio_ptr), 32'(4'b1000));
    check("single.gap", 32'(bus.fsm_state), 32'(3'b100));
    step("single.idle", 4'b0000);

    // Pointer wrap.
    step("wrap", 4'b0011);
    check("wrap.g", 32'(bus.grant), 32'(4'b0001));
    step("wrap.rel", 4'b0010);
    check("wrap.ptr", 32'(bus.prio_ptr), 32'(4'b0010));
    step("wrap.gap", 4'b0000);

    // All requesting: fixed 10-cycle cadence of 8 grant cycles, gap, idle.
    pulse_reset("all");
    pre_cnt = 0;
    for (int i = 1; i <= 50; i++) begin
      step("all", 4'b1111);
      if (bus.preempt) pre_cnt++;
      if (((i - 1) % 10) < MAX_HOLD)
        check("all.order", 32'(bus.grant), 32'(one << (((i - 1) / 10) % N)));
      else
        check("all.zero", 32'(bus.grant), 32'(0));
    end
    check("all.preempts", 32'(pre_cnt), 32'(5));

    // Drop on the same edge the hold limit is reached: normal release.
    pulse_reset("simul");
    for (int i = 0; i < MAX_HOLD; i++) step("simul", 4'b0001);
    step("simul.rel", 4'b0000);
    check("simul.pre", 32'(bus.preempt), 32'(0));
    check("simul.g", 32'(bus.grant), 32'(0));
    step("simul.gap", 4'b0000);

    // Reset in the middle of a tenure.
    pulse_reset("mid.pre");
    step("mid", 4'b0010);
    step("mid", 4'b0010);
    check("mid.g", 32'(bus.grant), 32'(4'b0010));
    pulse_reset("mid");
    step("mid.after", 4'b1111);
    check("mid.after.g", 32'(bus.grant), 32'(4'b0001));

    // Other-requester noise during a tenure.
    pulse_reset("noise");
    for (int i = 0; i < 6; i++) begin
      r = {3'($urandom_range(0, 7)), 1'b1};
      step("noise", r);
      check("noise.g", 32'(bus.grant), 32'(4'b0001));
      check("noise.ptr", 32'(bus.prio_ptr), 32'(4'b0001));
    end
    step("noise.rel", 4'b1110);
    step("noise.gap", 4'b1110);

    // Random level requests with occasional resets.
    r = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd");
      step("rnd", r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
